skinny_sbox8_ti3_pipe: RTL and testbench



---
 rtl/skinny_ti_pkg.sv | 58 +++++
 rtl/ti3_sbox8_cfn.sv | 23 ++
 rtl/skinny_sbox8_ti3_pipe.sv | 100 ++++++++++
 tb/tb_skinny_sbox8_ti3_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skinny_ti_pkg.sv
// Shared constants, per-stage register layouts and the output bit map for the
// 3-share threshold-implementation SKINNY 8-bit S-box.
package skinny_ti_pkg;

    localparam int SHARES       = 3;
    localparam int SBOX8_STAGES = 4;

    // Output bit position of each a-term (identical for all three shares)
    localparam logic [2:0] A0_BIT = 3'd6;
    localparam logic [2:0] A1_BIT = 3'd5;
    localparam logic [2:0] A2_BIT = 3'd2;
    localparam logic [2:0] A3_BIT = 3'd7;
    localparam logic [2:0] A4_BIT = 3'd3;
    localparam logic [2:0] A5_BIT = 3'd1;
    localparam logic [2:0] A6_BIT = 3'd4;
    localparam logic [2:0] A7_BIT = 3'd0;

    typedef logic [SHARES-1:0] shares_t;

    typedef struct packed {
        shares_t a0, a1, a2, b1, b2, b3, b5, b7;
    } st1_t;

    typedef struct packed {
        shares_t a0, a1, a2, a3, a4, b2, b3, b7;
    } st2_t;

    typedef struct packed {
        shares_t a0, a1, a2, a3, a4, a5, a6, b2;
    } st3_t;

    typedef struct packed {
        shares_t a0, a1, a2, a3, a4, a5, a6, a7;
    } st4_t;

    typedef struct packed {
        st1_t s1;
        st2_t s2;
        st3_t s3;
        st4_t s4;
    } pipe_t;

    // Places each a-term's share triple at its output bit position
    function automatic logic [7:0][SHARES-1:0] out_bits(st4_t s);
        logic [7:0][SHARES-1:0] r;
        r         = '0;
        r[A0_BIT] = s.a0;
        r[A1_BIT] = s.a1;
        r[A2_BIT] = s.a2;
        r[A3_BIT] = s.a3;
        r[A4_BIT] = s.a4;
        r[A5_BIT] = s.a5;
        r[A6_BIT] = s.a6;
        r[A7_BIT] = s.a7;
        return r;
    endfunction

endpackage

// File: rtl/ti3_sbox8_cfn.sv
// Combinational 3-share NOR-XOR cell: unshared it computes NOR(a,b)^z, and each
// output share leaves out one input share index of a and b.
module ti3_sbox8_cfn
    import skinny_ti_pkg::*;
(
    input  logic [SHARES-1:0] a,
    input  logic [SHARES-1:0] b,
    input  logic [SHARES-1:0] z,
    output logic [SHARES-1:0] f
);

    logic [SHARES-1:0] x;
    logic [SHARES-1:0] y;

    // Inverting share 0 turns the shared AND into a shared NOR
    assign x = {a[2], a[1], ~a[0]};
    assign y = {b[2], b[1], ~b[0]};

    assign f[0] = (x[1] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[1]) ^ z[0];
    assign f[1] = (x[2] & y[2]) ^ (x[0] & y[2]) ^ (x[2] & y[0]) ^ z[1];
    assign f[2] = (x[0] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[0]) ^ z[2];

endmodule

// File: rtl/skinny_sbox8_ti3_pipe.sv
// Multi-lane 3-share TI SKINNY S8 with four register-separated nonlinear stages
// and a valid/ready stream interface with full backpressure.
module skinny_sbox8_ti3_pipe
    import skinny_ti_pkg::*;
#(
    parameter int unsigned LANES    = 1,
    parameter int          RST_DATA = 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] si0,
    input  logic [8*LANES-1:0] si1,
    input  logic [8*LANES-1:0] si2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] bo0,
    output logic [8*LANES-1:0] bo1,
    output logic [8*LANES-1:0] bo2
);

    logic [SBOX8_STAGES-1:0] vld_reg;
    logic                    adv;

    // The whole pipe moves in lockstep; it only holds when the last stage is blocked
    assign adv       = ~vld_reg[SBOX8_STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_reg[SBOX8_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else if (adv) begin
            vld_reg <= {vld_reg[SBOX8_STAGES-2:0], in_valid};
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        shares_t                b_in  [8];
        shares_t                a_new [8];
        pipe_t                  pipe_reg;
        pipe_t                  pipe_next;
        logic [7:0][SHARES-1:0] ob;

        for (genvar gb = 0; gb < 8; gb++) begin : g_bit
            assign b_in[gb] = {si2[8*gi+gb], si1[8*gi+gb], si0[8*gi+gb]};
        end

        ti3_sbox8_cfn u_c0 (.a(b_in[7]),        .b(b_in[6]),        .z(b_in[4]),        .f(a_new[0]));
        ti3_sbox8_cfn u_c1 (.a(b_in[3]),        .b(b_in[2]),        .z(b_in[0]),        .f(a_new[1]));
        ti3_sbox8_cfn u_c2 (.a(b_in[2]),        .b(b_in[1]),        .z(b_in[6]),        .f(a_new[2]));
        ti3_sbox8_cfn u_c3 (.a(pipe_reg.s1.a0), .b(pipe_reg.s1.a1), .z(pipe_reg.s1.b5), .f(a_new[3]));
        ti3_sbox8_cfn u_c4 (.a(pipe_reg.s1.a1), .b(pipe_reg.s1.b3), .z(pipe_reg.s1.b1), .f(a_new[4]));
        ti3_sbox8_cfn u_c5 (.a(pipe_reg.s2.a2), .b(pipe_reg.s2.a3), .z(pipe_reg.s2.b7), .f(a_new[5]));
        ti3_sbox8_cfn u_c6 (.a(pipe_reg.s2.a3), .b(pipe_reg.s2.a0), .z(pipe_reg.s2.b3), .f(a_new[6]));
        ti3_sbox8_cfn u_c7 (.a(pipe_reg.s3.a4), .b(pipe_reg.s3.a5), .z(pipe_reg.s3.b2), .f(a_new[7]));

        always_comb begin
            pipe_next    = pipe_reg;
            pipe_next.s1 = '{a0: a_new[0], a1: a_new[1], a2: a_new[2],
                             b1: b_in[1], b2: b_in[2], b3: b_in[3], b5: b_in[5], b7: b_in[7]};
            pipe_next.s2 = '{a0: pipe_reg.s1.a0, a1: pipe_reg.s1.a1, a2: pipe_reg.s1.a2,
                             a3: a_new[3], a4: a_new[4],
                             b2: pipe_reg.s1.b2, b3: pipe_reg.s1.b3, b7: pipe_reg.s1.b7};
            pipe_next.s3 = '{a0: pipe_reg.s2.a0, a1: pipe_reg.s2.a1, a2: pipe_reg.s2.a2,
                             a3: pipe_reg.s2.a3, a4: pipe_reg.s2.a4,
                             a5: a_new[5], a6: a_new[6], b2: pipe_reg.s2.b2};
            pipe_next.s4 = '{a0: pipe_reg.s3.a0, a1: pipe_reg.s3.a1, a2: pipe_reg.s3.a2,
                             a3: pipe_reg.s3.a3, a4: pipe_reg.s3.a4, a5: pipe_reg.s3.a5,
                             a6: pipe_reg.s3.a6, a7: a_new[7]};
        end

        if (RST_DATA != 0) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_reg <= '0;
                end else if (adv) begin
                    pipe_reg <= pipe_next;
                end
            end
        end else begin : g_norst
            always_ff @(posedge clk) begin
                if (adv) begin
                    pipe_reg <= pipe_next;
                end
            end
        end

        assign ob = out_bits(pipe_reg.s4);

        for (genvar gb = 0; gb < 8; gb++) begin : g_out
            assign bo0[8*gi+gb] = ob[gb][0];
            assign bo1[8*gi+gb] = ob[gb][1];
            assign bo2[8*gi+gb] = ob[gb][2];
        end
    end

endmodule

// File: tb/tb_skinny_sbox8_ti3_pipe.sv
// Self-checking bench for the 4-lane TI S-box pipe: known-answer table, full
// input sweep, random flow control, stall, mid-flight reset and bubble patterns.
module tb_skinny_sbox8_ti3_pipe;

    localparam int NL = 4;
    localparam int W  = 8 * NL;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] si0, si1, si2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bo0, bo1, bo2;

    skinny_sbox8_ti3_pipe #(.LANES(NL), .RST_DATA(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .si0       (si0),
        .si1       (si1),
        .si2       (si2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bo0       (bo0),
        .bo1       (bo1),
        .bo2       (bo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] s8;
    } vec_t;

    vec_t         tab [5];
    int           total = 0;
    int           bad   = 0;
    int           tick_n = 0;
    int           n_out = 0;
    bit           lat_chk = 1'b1;
    bit           acc;
    bit           prev_stall = 1'b0;
    logic         last_ov;
    logic [3*W-1:0] hold_bo;
    logic [W-1:0] exp_word;
    logic [W-1:0] sb_q [$];
    int           cyc_q [$];

    // SKINNY S8 as four NOR-mix rounds with bit permutations and a final swap
    function automatic logic [7:0] s8_ref(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int r = 0; r < 4; r++) begin
            x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
            if (r < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
                  | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [W-1:0] lanes_ref(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) r[8*l +: 8] = s8_ref(w[8*l +: 8]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic load_beat(input logic [W-1:0] x, input logic [W-1:0] e);
        si0      = $urandom;
        si1      = $urandom;
        si2      = x ^ si0 ^ si1;
        exp_word = e;
    endtask

    // One clock: sample handshakes at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        logic [W-1:0] e;
        int           c;
        @(negedge clk);
        if (prev_stall)
            chk("stall_hold", {out_valid, bo0, bo1, bo2}, {1'b1, hold_bo});
        acc = in_valid && in_ready;
        if (acc) begin
            sb_q.push_back(exp_word);
            cyc_q.push_back(tick_n);
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got out=%h with nothing in flight (t=%0t)", bo0 ^ bo1 ^ bo2, $time);
            end else begin
                e = sb_q.pop_front();
                c = cyc_q.pop_front();
                $display("beat %0d: out=%h exp=%h lat=%0d", n_out, bo0 ^ bo1 ^ bo2, e, tick_n - c);
                chk("data", bo0 ^ bo1 ^ bo2, e);
                if (lat_chk) chk("latency", tick_n - c, 4);
                n_out++;
            end
        end
        prev_stall = out_valid && !out_ready;
        hold_bo    = {bo0, bo1, bo2};
        last_ov    = out_valid;
        @(posedge clk);
        #1;
        tick_n++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        chk("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [11:0]  ov_pat, ov_exp;
        int           base, k, stall_n;
        bit           stall_done;

        tab[0] = '{x: 8'h00, s8: 8'h65};
        tab[1] = '{x: 8'h01, s8: 8'h4C};
        tab[2] = '{x: 8'hFF, s8: 8'hFF};
        tab[3] = '{x: 8'h80, s8: 8'h36};
        tab[4] = '{x: 8'h02, s8: 8'h6A};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        si0 = '0; si1 = '0; si2 = '0; exp_word = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bo", {bo0, bo1, bo2}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // All-zero shares first, then the table back to back with random splits
        si0 = '0; si1 = '0; si2 = '0; exp_word = {NL{tab[0].s8}};
        in_valid = 1'b1;
        tick();
        for (int i = 1; i < 5; i++) begin
            load_beat({NL{tab[i].x}}, {NL{tab[i].s8}});
            tick();
        end
        drain();

        // Every byte value on lane 0, random values on the other lanes
        for (int v = 0; v < 256; v++) begin
            x = ($urandom & 32'hFFFF_FF00) | v;
            load_beat(x, lanes_ref(x));
            in_valid = 1'b1;
            tick();
        end
        drain();

        // Random valid and ready with data held until accepted
        lat_chk  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc) begin
                x = $urandom;
                load_beat(x, lanes_ref(x));
                in_valid = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Six beats, output stalled for 3 cycles once beat 2 reaches the output
        base = n_out; k = 0; stall_n = 0; stall_done = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (k < 6 && !in_valid) begin
                x = $urandom;
                load_beat(x, lanes_ref(x));
                in_valid = 1'b1;
            end
            if (!stall_done && stall_n == 0 && out_valid && n_out == base + 1) stall_n = 3;
            out_ready = (stall_n == 0);
            #1;
            if (stall_n > 0) chk("stall_in_ready", in_ready, 0);
            tick();
            if (stall_n > 0) begin
                stall_n--;
                if (stall_n == 0) stall_done = 1'b1;
            end
            if (acc) begin
                k++;
                in_valid = 1'b0;
            end
        end
        chk("stall_seen", stall_done, 1);
        chk("stall_count", n_out - base, 6);
        drain();

        // Asynchronous reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            x = $urandom;
            load_beat(x, lanes_ref(x));
            in_valid = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_bo", {bo0, bo1, bo2}, 0);
        chk("async_rst_in_ready", in_ready, 1);
        sb_q.delete();
        cyc_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("dropped_beats", last_ov, 0);
        lat_chk = 1'b1;
        x = $urandom;
        load_beat(x, lanes_ref(x));
        in_valid = 1'b1;
        tick();
        drain();

        // Alternating valid: output valid pattern is the input pattern delayed by 4
        ov_pat = '0;
        ov_exp = '0;
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            load_beat(x, lanes_ref(x));
            in_valid = (i < 8) && (i % 2 == 0);
            if (i >= 4 && (i - 4) % 2 == 0) ov_exp[i] = 1'b1;
            tick();
            ov_pat[i] = last_ov;
        end
        chk("bubble_pattern", ov_pat, ov_exp);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
